// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC-driven memory read into a single-entry instruction register
module instr_fetch #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_pc_in,
    input  logic              i_flush,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_ir_out,
    output logic [ADDR_W-1:0] o_ir_pc,
    output logic              o_ir_valid,
    input  logic              i_ir_taken,
    output logic              o_busy,
    output logic              o_fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [DATA_W-1:0] r_ir_out;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic              r_busy;
    logic              r_fetch_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_ir_out    <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_fetch_req) begin
                        r_mem_addr <= i_pc_in;
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= 8'd0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // flush beats a same-cycle ack, and ack beats the timeout
                    if (i_flush) begin
                        r_mem_rd <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (i_mem_ack) begin
                        r_ir_out   <= i_mem_data;
                        r_ir_pc    <= r_mem_addr;
                        r_ir_valid <= 1'b1;
                        r_mem_rd   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_FULL;
                    end else if (r_wait_cnt == LP_LAST_WAIT) begin
                        r_mem_rd    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_FULL: begin
                    if (i_flush) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (i_ir_taken) begin
                        r_ir_valid <= 1'b0;
                        if (i_fetch_req) begin
                            r_mem_addr <= i_pc_in;
                            r_mem_rd   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_wait_cnt <= 8'd0;
                            r_state    <= S_BUSY;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_rd    = r_mem_rd;
    assign o_ir_out    = r_ir_out;
    assign o_ir_pc     = r_ir_pc;
    assign o_ir_valid  = r_ir_valid;
    assign o_busy      = r_busy;
    assign o_fetch_err = r_fetch_err;

endmodule
